hil_event_capture: RTL and testbench
====================================

// Module: hil_event_capture
// PURPOSE
// Watches a vector of DUT signals, time-stamps every cycle on which any of them changes, and
// buffers the events in a FIFO. A valid/ready stream carries the events to the host co-sim bridge.
// Sits directly downstream of the DUT (e.g. fulladder x/y/cin/A/cout) and upstream of the bridge.
// Hardware replacement for per-signal change callbacks; one event word carries all changes of a cycle.
// PARAMETERS
// NUM_SIG  5   number of monitored 1-bit signals
// TS_W     16  timestamp width (cycles since capture start)
// DEPTH    8   FIFO depth in events (power of two, >=2)
// CNT_W    8   dropped-event counter width
// PORTS
// clk        in   1                 single clock; all logic on rising edge
// rst        in   1                 asynchronous, active-high reset
// enable     in   1                 capture enable (level)
// sig_in     in   NUM_SIG           monitored signals, synchronous to clk
// out_valid  out  1                 head event available
// out_ready  in   1                 host accepts head event
// out_data   out  2+TS_W+2*NUM_SIG  {flags[1:0], ts, mask, val}
// fill       out  $clog2(DEPTH)+1   FIFO occupancy
// drop_cnt   out  CNT_W             events lost to overflow, saturating
// overflow   out  1                 sticky: set on first drop
// BEHAVIOUR
// Reset: state=IDLE, FIFO empty, out_valid=0, out_data=0, fill=0, drop_cnt=0, overflow=0, prev=0, ts=0.
// FSM: IDLE -(enable=1)-> SNAP -(1 cycle)-> RUN -(enable=0)-> IDLE.
// SNAP -(enable=0)-> IDLE; the snapshot is still pushed.
// - IDLE: no pushes; ts held at 0; prev<=sig_in every cycle.
// - SNAP: push snapshot {flags=2'b01, ts=0, mask=all ones, val=sig_in}; prev<=sig_in.
// - RUN: ts increments each cycle, wraps 2^TS_W-1 -> 0.
//   If (sig_in^prev)!=0: push {flags, ts, mask=sig_in^prev, val=sig_in}.
//   Else if ts just wrapped to 0: push a wrap marker {ts=0, mask=0, val=sig_in}.
//   prev<=sig_in every cycle.
// flags[1] (lost): set on the first successfully pushed event after >=1 drop; then cleared.
// Push on full FIFO with no pop in the same cycle:
// - event is dropped and drop_cnt increments (holds at max);
// - overflow is set (sticky until rst) and lost_pending is set.
// Simultaneous push and pop on a full FIFO: both succeed and fill is unchanged.
// Output: first-word-fall-through. Change at sig_in in cycle t -> out_valid=1 in cycle t+1 if the
// FIFO was empty. Transfer when out_valid&out_ready. out_data is stable while out_valid&!out_ready.
// out_data=0 when empty.
// Disable mid-RUN: FSM returns to IDLE next cycle and ts clears. FIFO contents are kept and drain.
// drop_cnt and overflow are kept. lost_pending is kept.
// Re-enable always produces a fresh snapshot at ts=0.
// rst mid-operation: immediate return to reset values; buffered events are discarded.
// TESTING (NUM_SIG=5, TS_W=16, DEPTH=8, out_ready=1 unless stated)
// 1. rst, enable=1 with sig_in=5'b00101 -> first event flags=01, ts=0, mask=11111, val=00101.
// 2. RUN; at ts=3 flip bits 0 and 4 (sig_in 00101 -> 10100) -> one event: ts=3, mask=10001,
//    val=10100, flags=00; out_valid 1 cycle after the change.
// 3. out_ready=0, toggle sig_in every cycle for 12 cycles -> fill=8, drop_cnt=4, overflow=1.
//    Then out_ready=1: 8 events drain in order; next new event has flags[1]=1; the one after has 0.
// 4. Force ts to 16'hFFFF, hold sig_in constant -> wrap marker ts=0, mask=0.
//    Repeat with a change on the wrap cycle -> single event ts=0 with nonzero mask, no extra marker.
// 5. 3 events buffered, drop enable -> next cycle state IDLE, no new pushes, all 3 drain.
//    Re-enable -> snapshot at ts=0.
// 6. Full FIFO with push and pop in the same cycle -> fill stays 8, drop_cnt unchanged.
//    Assert rst mid-burst -> out_valid=0 and fill=0 asynchronously.

Source files
------------

// File: rtl/hil_event_capture_if.sv
// rtl/hil_event_capture_if.sv - event stream towards the host co-sim bridge
interface hil_event_capture_if #(
  parameter int DATA_W = 28
);
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/hil_event_capture.sv
// rtl/hil_event_capture.sv - time-stamped change capture of DUT signals into a FWFT event FIFO
module hil_event_capture #(
  parameter int NUM_SIG = 5,
  parameter int TS_W    = 16,
  parameter int DEPTH   = 8,
  parameter int CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [NUM_SIG-1:0]       sig_in,
  hil_event_capture_if.master      out_if,
  output logic [$clog2(DEPTH):0]   fill,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic                     overflow
);

  localparam int AW     = $clog2(DEPTH);
  localparam int DATA_W = 2 + TS_W + 2*NUM_SIG;

  typedef enum logic [1:0] {S_IDLE, S_SNAP, S_RUN} state_t;

  state_t              state_q, state_d;
  logic [TS_W-1:0]     ts_q, ts_d;
  logic [NUM_SIG-1:0]  prev_q;
  logic [AW:0]         wr_ptr_q, rd_ptr_q;
  logic                lost_q, lost_d;
  logic [CNT_W-1:0]    drop_q, drop_d;
  logic                ovf_q, ovf_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                push, push_ok, pop, full, empty, drop;
  logic [NUM_SIG-1:0]  diff;
  logic [DATA_W-1:0]   push_word;
  logic [AW:0]         count;

  // Capture sequencing: a snapshot cycle always precedes change tracking
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (enable) state_d = S_SNAP;
      S_SNAP:  state_d = enable ? S_RUN : S_IDLE;
      S_RUN:   if (!enable) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Event word formation: snapshot, change event, or wrap marker when nothing changed
  always_comb begin
    diff      = sig_in ^ prev_q;
    push      = 1'b0;
    push_word = '0;
    case (state_q)
      S_SNAP: begin
        push      = 1'b1;
        push_word = {lost_q, 1'b1, {TS_W{1'b0}}, {NUM_SIG{1'b1}}, sig_in};
      end
      S_RUN: begin
        if (diff != '0) begin
          push      = 1'b1;
          push_word = {lost_q, 1'b0, ts_q, diff, sig_in};
        end else if (ts_q == '0) begin
          push      = 1'b1;
          push_word = {lost_q, 1'b0, ts_q, {NUM_SIG{1'b0}}, sig_in};
        end
      end
      default: ;
    endcase
  end

  // FIFO bookkeeping; a pop in the same cycle frees the slot a full-FIFO push needs
  always_comb begin
    count   = wr_ptr_q - rd_ptr_q;
    full    = (count == (AW+1)'(DEPTH));
    empty   = (count == '0);
    pop     = !empty && out_if.out_ready;
    push_ok = push && (!full || pop);
    drop    = push && full && !pop;
    lost_d  = lost_q;
    if (push_ok) lost_d = 1'b0;
    else if (drop) lost_d = 1'b1;
    drop_d  = (drop && (drop_q != {CNT_W{1'b1}})) ? drop_q + CNT_W'(1) : drop_q;
    ovf_d   = ovf_q | drop;
    ts_d    = ((state_q == S_IDLE) || !enable) ? '0 : ts_q + TS_W'(1);
  end

  // Control state with asynchronous reset; buffered events are discarded on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ts_q     <= '0;
      prev_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      lost_q   <= 1'b0;
      drop_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ts_q     <= ts_d;
      prev_q   <= sig_in;
      lost_q   <= lost_d;
      drop_q   <= drop_d;
      ovf_q    <= ovf_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // Event storage; contents are only observable through the pointers, so no reset
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_word;
  end

  // First-word-fall-through head, forced to zero when empty
  always_comb begin
    out_if.out_valid = !empty;
    out_if.out_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    fill             = count;
    drop_cnt         = drop_q;
    overflow         = ovf_q;
  end

endmodule

// File: tb/tb_hil_event_capture.sv
// tb/tb_hil_event_capture.sv - self-checking bench for hil_event_capture
module tb_hil_event_capture;

  localparam int NS = 5;
  localparam int DW = 28;
  localparam int WDW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // main instance (TS_W=16)
  logic          en = 1'b0;
  logic [NS-1:0] sig = '0;
  logic [3:0]    fill;
  logic [7:0]    drop_cnt;
  logic          overflow;
  hil_event_capture_if #(.DATA_W(DW)) bus ();

  hil_event_capture #(.NUM_SIG(5), .TS_W(16), .DEPTH(8), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .enable(en), .sig_in(sig), .out_if(bus),
    .fill(fill), .drop_cnt(drop_cnt), .overflow(overflow)
  );

  // short-timestamp instance for wrap behaviour (TS_W=4)
  logic          w_en = 1'b0;
  logic [NS-1:0] w_sig = '0;
  logic [3:0]    w_fill;
  logic [7:0]    w_drop;
  logic          w_ovf;
  hil_event_capture_if #(.DATA_W(WDW)) wbus ();

  hil_event_capture #(.NUM_SIG(5), .TS_W(4), .DEPTH(8), .CNT_W(8)) u_dut_w (
    .clk(clk), .rst(rst), .enable(w_en), .sig_in(w_sig), .out_if(wbus),
    .fill(w_fill), .drop_cnt(w_drop), .overflow(w_ovf)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: event list plus age since capture start (-1 = not capturing)
  logic [DW-1:0] mq[$];
  int            m_age;
  logic [NS-1:0] m_prev;
  int            m_drop;
  bit            m_ovf;
  bit            m_lost;

  task automatic model_reset();
    mq.delete();
    m_age = -1; m_prev = '0; m_drop = 0; m_ovf = 0; m_lost = 0;
  endtask

  task automatic model_step(input logic e, input logic [NS-1:0] s, input logic rdy);
    bit            do_push;
    bit            popped;
    int            sz;
    logic [DW-1:0] w;
    logic [15:0]   ts;
    logic [NS-1:0] mask;
    sz = mq.size();
    popped = (sz > 0) && rdy;
    do_push = 0;
    w = '0;
    if (m_age == 0) begin
      do_push = 1;
      w = {m_lost, 1'b1, 16'h0, 5'h1f, s};
    end else if (m_age > 0) begin
      ts = 16'(m_age % 65536);
      mask = s ^ m_prev;
      if (mask != 0) begin
        do_push = 1; w = {m_lost, 1'b0, ts, mask, s};
      end else if (ts == 0) begin
        do_push = 1; w = {m_lost, 1'b0, ts, 5'h00, s};
      end
    end
    if (popped) mq.delete(0);
    if (do_push) begin
      if (sz < 8 || popped) begin
        mq.push_back(w); m_lost = 0;
      end else begin
        if (m_drop < 255) m_drop++;
        m_ovf = 1; m_lost = 1;
      end
    end
    m_prev = s;
    if (m_age < 0) m_age = e ? 0 : -1;
    else m_age = e ? m_age + 1 : -1;
  endtask

  // One clock of the main instance, compared against the model after the edge
  task automatic step(input logic e, input logic [NS-1:0] s, input logic rdy);
    en = e; sig = s; bus.out_ready = rdy;
    model_step(e, s, rdy);
    @(posedge clk);
    @(negedge clk);
    chk("valid", 64'(bus.out_valid), 64'(mq.size() > 0));
    chk("data", 64'(bus.out_data), (mq.size() > 0) ? 64'(mq[0]) : 64'd0);
    chk("fill", 64'(fill), 64'(mq.size()));
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    chk("overflow", 64'(overflow), 64'(m_ovf));
  endtask

  typedef struct {
    logic          en;
    logic [NS-1:0] sig;
    logic          rdy;
    logic          exp_valid;
    logic [DW-1:0] exp_data;
    logic [3:0]    exp_fill;
  } vec_t;

  vec_t vecs[7];
  logic [WDW-1:0] wcap[$];
  logic [NS-1:0]  cur;

  initial begin
    vecs[0] = '{1'b0, 5'b00101, 1'b0, 1'b0, 28'h0, 4'd0};
    vecs[1] = '{1'b1, 5'b00101, 1'b0, 1'b0, 28'h0, 4'd0};
    vecs[2] = '{1'b1, 5'b00101, 1'b0, 1'b1, {2'b01, 16'd0, 5'b11111, 5'b00101}, 4'd1};
    vecs[3] = '{1'b1, 5'b00101, 1'b1, 1'b0, 28'h0, 4'd0};
    vecs[4] = '{1'b1, 5'b00101, 1'b1, 1'b0, 28'h0, 4'd0};
    vecs[5] = '{1'b1, 5'b10100, 1'b1, 1'b1, {2'b00, 16'd3, 5'b10001, 5'b10100}, 4'd1};
    vecs[6] = '{1'b1, 5'b10100, 1'b1, 1'b0, 28'h0, 4'd0};

    bus.out_ready = 1'b1;
    wbus.out_ready = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset valid", 64'(bus.out_valid), 64'd0);
    chk("reset data", 64'(bus.out_data), 64'd0);
    chk("reset fill", 64'(fill), 64'd0);
    chk("reset drop", 64'(drop_cnt), 64'd0);
    chk("reset ovf", 64'(overflow), 64'd0);
    rst = 1'b0;

    // timestamp wrap: marker on a quiet wrap cycle, single change event on a busy one
    w_sig = 5'h03;
    for (int k = 0; k <= 40; k++) begin
      w_en = 1'b1;
      w_sig = (k >= 33) ? 5'h01 : 5'h03;
      @(posedge clk);
      @(negedge clk);
      if (wbus.out_valid) wcap.push_back(wbus.out_data);
    end
    chk("wrap count", 64'(wcap.size()), 64'd3);
    if (wcap.size() == 3) begin
      chk("wrap snapshot", 64'(wcap[0]), 64'({2'b01, 4'h0, 5'h1f, 5'h03}));
      chk("wrap marker", 64'(wcap[1]), 64'({2'b00, 4'h0, 5'h00, 5'h03}));
      chk("wrap change", 64'(wcap[2]), 64'({2'b00, 4'h0, 5'h02, 5'h01}));
    end
    w_en = 1'b0;

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // snapshot and first change event from a fixed vector table
    for (int i = 0; i < 7; i++) begin
      en = vecs[i].en; sig = vecs[i].sig; bus.out_ready = vecs[i].rdy;
      model_step(vecs[i].en, vecs[i].sig, vecs[i].rdy);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d valid", i), 64'(bus.out_valid), 64'(vecs[i].exp_valid));
      chk($sformatf("vec%0d data", i), 64'(bus.out_data), 64'(vecs[i].exp_data));
      chk($sformatf("vec%0d fill", i), 64'(fill), 64'(vecs[i].exp_fill));
    end

    // overflow: 12 changes with the host stalled
    cur = 5'b10100;
    for (int i = 0; i < 12; i++) begin
      cur = ~cur;
      step(1'b1, cur, 1'b0);
    end
    chk("ovf fill", 64'(fill), 64'd8);
    chk("ovf drop", 64'(drop_cnt), 64'd4);
    chk("ovf sticky", 64'(overflow), 64'd1);
    for (int i = 0; i < 8; i++) step(1'b1, cur, 1'b1);
    cur = cur ^ 5'b00001;
    step(1'b1, cur, 1'b1);
    chk("lost flag set", 64'(bus.out_data[DW-1]), 64'd1);
    cur = cur ^ 5'b00010;
    step(1'b1, cur, 1'b1);
    chk("lost flag clear", 64'(bus.out_data[DW-1]), 64'd0);
    step(1'b1, cur, 1'b1);

    // disable with events buffered, drain, re-enable
    for (int i = 0; i < 3; i++) begin
      cur = cur ^ 5'b00100;
      step(1'b1, cur, 1'b0);
    end
    chk("buffered 3", 64'(fill), 64'd3);
    step(1'b0, cur, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cur = cur ^ 5'b01000;
      step(1'b0, cur, 1'b0);
    end
    chk("idle no push", 64'(fill), 64'd3);
    for (int i = 0; i < 3; i++) step(1'b0, cur, 1'b1);
    chk("drained", 64'(fill), 64'd0);
    step(1'b1, cur, 1'b0);
    step(1'b1, cur, 1'b0);
    chk("re-snapshot", 64'(bus.out_data), 64'({2'b01, 16'd0, 5'h1f, cur}));

    // full FIFO with simultaneous push and pop
    step(1'b1, cur, 1'b1);
    for (int i = 0; i < 8; i++) begin
      cur = ~cur;
      step(1'b1, cur, 1'b0);
    end
    chk("full", 64'(fill), 64'd8);
    for (int i = 0; i < 4; i++) begin
      cur = ~cur;
      step(1'b1, cur, 1'b1);
      chk("full push+pop fill", 64'(fill), 64'd8);
      chk("full push+pop drop", 64'(drop_cnt), 64'd4);
    end

    // asynchronous reset mid-burst
    rst = 1'b1;
    #1;
    chk("async rst valid", 64'(bus.out_valid), 64'd0);
    chk("async rst fill", 64'(fill), 64'd0);
    chk("async rst drop", 64'(drop_cnt), 64'd0);
    #1;
    rst = 1'b0;
    model_reset();

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic          r_en;
      logic [NS-1:0] r_sig;
      logic          r_rdy;
      r_en  = ($urandom_range(0, 15) != 0);
      r_sig = ($urandom_range(0, 2) == 0) ? 5'($urandom) : sig;
      r_rdy = ($urandom_range(0, 3) != 0) ? (i % 64 < 40) : 1'b0;
      step(r_en, r_sig, r_rdy);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
